lector_contadores: RTL and testbench
====================================

Name: lector_contadores

Overview:
- Requester-side FSM for the pop-counter read interface (req / idx / IDLE in, valid_contador / contador_out back).
- On a start pulse, sweeps idx 0..3 and issues one single-cycle req per index, only while IDLE is high.
- Captures each 5-bit count and reports all four counts plus their sum, with a done pulse.
- Sits between the test/control layer and the per-FIFO pop counters; flags a timeout error when the responder never answers.

Parameters:
- CNT_W, 5, width of each returned count.
- N_IDX, 4, number of counters swept, idx 0..N_IDX-1.
- TIMEOUT, 4, cycles to wait in ESPERAR for valid_contador before declaring error (1..15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset; all state clears immediately on reset=0.
- start  in  1  one-cycle request to begin a sweep; ignored while busy=1.
- IDLE  in  1  system idle; counters may only be read while high.
- valid_contador  in  1  responder data-valid (may be sticky high).
- contador_out  in  CNT_W  responder count value.
- req  out  1  read request to responder.
- idx  out  2  index of counter requested.
- cnt0, cnt1, cnt2, cnt3  out  CNT_W each  captured counts for FIFO 0..3.
- total  out  CNT_W+2  sum cnt0+cnt1+cnt2+cnt3.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at sweep end (success or error).
- error  out  1  sticky timeout flag; cleared by the next accepted start or by reset.

Behaviour:
- Reset values:
  - req=0, idx=0, cnt0..cnt3=0, total=0, busy=0, done=0, error=0.
  - State=REPOSO, pointer=0, timer=0.
- States: REPOSO, ARMAR, PEDIR, ESPERAR, FIN.
- REPOSO: on start=1, go to ARMAR; set busy=1, clear error, pointer=0.
- ARMAR: wait for IDLE=1. When IDLE=1, drive idx=pointer and go to PEDIR.
- PEDIR (exactly one cycle):
  - req=1, idx=pointer; both registered outputs, stable for the whole cycle.
  - Latch flag ok = IDLE at the closing edge of this cycle.
  - Next state is ESPERAR.
- ESPERAR:
  - req=0, idx holds. The responder's registered data is visible in the first ESPERAR cycle.
  - If ok=0 (IDLE fell before the req edge): the request was ignored by the responder. Go to ARMAR and retry the same pointer; no capture, no timer advance.
  - Else, if valid_contador=1: capture contador_out into cnt[pointer].
    - If pointer=N_IDX-1, go to FIN.
    - Otherwise increment pointer and go to ARMAR.
  - Else, increment timer. When timer reaches TIMEOUT, set error=1 and go to FIN; cnt registers not yet captured keep their previous values.
  - timer clears on every entry to ESPERAR.
- Latency: a fully idle sweep takes 3 cycles per index (ARMAR, PEDIR, ESPERAR). From start to the done pulse is 12 cycles plus 1 (FIN).
- FIN:
  - total <= zero-extended sum of cnt0..cnt3, using the value captured this sweep. Max 4*31=124, fits CNT_W+2 bits, no overflow.
  - done=1 for this single cycle; busy drops to 0 on the edge leaving FIN. Next state is REPOSO.
- A sticky valid_contador is accepted as-is: data is always taken in the first ESPERAR cycle after a valid req. The responder updates contador_out on that same edge, so the data is fresh.
- start while busy=1 is ignored, with no queuing.
- start and IDLE=0 together: the request is accepted and the FSM waits in ARMAR indefinitely; no timeout applies in ARMAR.
- Reset asserted mid-sweep aborts immediately: all outputs return to reset values, and partial counts are discarded (cleared).
- idx wraps only via pointer reset; pointer never exceeds N_IDX-1.

Decomposition:
- Shared package holds:
  - State encoding constants REPOSO..FIN.
  - CNT_W and N_IDX defaults.
  - IDX_W=2.
- Timeout timer as one small sub-module, temporizador: load/clear, increment, and a terminal-count flag. Used here and reusable for other handshake watchdogs.
- Remaining logic stays flat in one module.

Test Plan:
- Basic sweep: counters preloaded to 3,7,0,31, IDLE=1, start pulse.
  - req pulses with idx 0,1,2,3 every 3 cycles.
  - cnt0..3 = 3,7,0,31; total=41; done pulses 13 cycles after start; error=0.
- IDLE gating: start with IDLE=0 for 10 cycles, then IDLE=1.
  - No req while IDLE=0.
  - Sweep completes normally 12 cycles after IDLE rises.
- IDLE drop during PEDIR: IDLE falls at the edge of the idx=2 request.
  - The idx=2 req is retried once IDLE returns.
  - cnt2 matches the counter value; no duplicate capture.
- Timeout: responder holds valid_contador=0.
  - After TIMEOUT=4 cycles in ESPERAR on idx 0: error=1, done pulses, cnt0..3 unchanged (0).
  - The next start clears error.
- Reset mid-sweep: assert reset=0 while in ESPERAR on idx 1.
  - All outputs are 0 immediately (asynchronous).
  - After release, a new start sweeps from idx 0.
- Max values: all counters 31 → total=124, with no overflow or truncation.

Source files
------------

// File: rtl/lector_contadores_pkg.sv
// Shared definitions for the pop-counter reader: sweep states and default widths.
package lector_contadores_pkg;

    typedef enum logic [2:0] {
        REPOSO,
        ARMAR,
        PEDIR,
        ESPERAR,
        FIN
    } estado_t;

    localparam int unsigned CNT_W_DEF = 5;
    localparam int unsigned N_IDX_DEF = 4;
    localparam int unsigned IDX_W     = 2;

endpackage

// File: rtl/lector_contadores_temporizador.sv
// Small watchdog counter: clear, increment, and a flag raised when the next
// increment lands on the terminal count TC.
module temporizador #(
    parameter int unsigned W  = 4,
    parameter int unsigned TC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic ultimo
);

    logic [W-1:0] cuenta;

    // Clear has priority over increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cuenta <= '0;
        end else if (clr) begin
            cuenta <= '0;
        end else if (inc) begin
            cuenta <= cuenta + 1'b1;
        end
    end

    // Looks one step ahead so the owner can act on the very increment that
    // reaches TC.
    assign ultimo = (cuenta == W'(TC - 1));

endmodule

// File: rtl/lector_contadores.sv
// Requester-side sweep of the pop-counter read interface: asks for each counter
// in turn while the system is idle, captures the answers and reports their sum.
module lector_contadores
    import lector_contadores_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned N_IDX   = N_IDX_DEF,
    parameter int unsigned TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             IDLE,
    input  logic             valid_contador,
    input  logic [CNT_W-1:0] contador_out,
    output logic             req,
    output logic [IDX_W-1:0] idx,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3,
    output logic [CNT_W+1:0] total,
    output logic             busy,
    output logic             done,
    output logic             error
);

    estado_t          estado;
    logic [IDX_W-1:0] ptr;
    logic             ok;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [CNT_W+1:0] suma;
    logic             captura;
    logic             tmr_clr;
    logic             tmr_inc;
    logic             tmr_ultimo;

    assign captura = (estado == ESPERAR) && ok && valid_contador;
    assign tmr_clr = (estado == PEDIR);
    assign tmr_inc = (estado == ESPERAR) && ok && !valid_contador;

    temporizador #(
        .W  (4),
        .TC (TIMEOUT)
    ) u_temporizador (
        .clk    (clk),
        .reset  (reset),
        .clr    (tmr_clr),
        .inc    (tmr_inc),
        .ultimo (tmr_ultimo)
    );

    // Next counter values, so total can be formed on the same edge as the
    // final capture and be valid together with done.
    always_comb begin
        cnt_d = cnt_q;
        if (captura) begin
            cnt_d[ptr] = contador_out;
        end
        suma = {2'b00, cnt_d[0]} + {2'b00, cnt_d[1]}
             + {2'b00, cnt_d[2]} + {2'b00, cnt_d[3]};
    end

    // Sweep sequencer with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado <= REPOSO;
            ptr    <= '0;
            ok     <= 1'b0;
            cnt_q  <= '{default: '0};
            req    <= 1'b0;
            idx    <= '0;
            total  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
        end else begin
            done  <= 1'b0;
            cnt_q <= cnt_d;
            case (estado)
                REPOSO: begin
                    req <= 1'b0;
                    if (start) begin
                        estado <= ARMAR;
                        busy   <= 1'b1;
                        error  <= 1'b0;
                        ptr    <= '0;
                    end
                end
                ARMAR: begin
                    if (IDLE) begin
                        idx    <= ptr;
                        req    <= 1'b1;
                        estado <= PEDIR;
                    end
                end
                PEDIR: begin
                    req    <= 1'b0;
                    ok     <= IDLE;
                    estado <= ESPERAR;
                end
                ESPERAR: begin
                    if (!ok) begin
                        estado <= ARMAR;
                    end else if (valid_contador) begin
                        if (ptr == IDX_W'(N_IDX - 1)) begin
                            total  <= suma;
                            done   <= 1'b1;
                            estado <= FIN;
                        end else begin
                            ptr    <= ptr + 1'b1;
                            estado <= ARMAR;
                        end
                    end else if (tmr_ultimo) begin
                        error  <= 1'b1;
                        total  <= suma;
                        done   <= 1'b1;
                        estado <= FIN;
                    end
                end
                FIN: begin
                    busy   <= 1'b0;
                    estado <= REPOSO;
                end
                default: estado <= REPOSO;
            endcase
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];

endmodule

// File: tb/tb_lector_contadores.sv
// Bench for lector_contadores: behavioural responder, cycle model compared on
// every falling edge, plus directed literal expectations per scenario.
module tb_lector_contadores;

    localparam int CNT_W   = 5;
    localparam int N_IDX   = 4;
    localparam int TIMEOUT = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             IDLE = 1'b0;
    logic             valid_contador;
    logic [CNT_W-1:0] contador_out;
    logic             req;
    logic [1:0]       idx;
    logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;
    logic [CNT_W+1:0] total;
    logic             busy, done, error;

    int nchk = 0;
    int nerr = 0;

    lector_contadores #(
        .CNT_W   (CNT_W),
        .N_IDX   (N_IDX),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .IDLE           (IDLE),
        .valid_contador (valid_contador),
        .contador_out   (contador_out),
        .req            (req),
        .idx            (idx),
        .cnt0           (cnt0),
        .cnt1           (cnt1),
        .cnt2           (cnt2),
        .cnt3           (cnt3),
        .total          (total),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Responder: answers a req seen with IDLE high on the same edge.
    int mem [4];
    bit resp_on = 1'b1;
    bit sticky  = 1'b0;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_contador <= 1'b0;
            contador_out   <= '0;
        end else if (req && IDLE && resp_on) begin
            valid_contador <= 1'b1;
            contador_out   <= CNT_W'(mem[idx]);
        end else if (!sticky) begin
            valid_contador <= 1'b0;
        end
    end

    // Reference model of the sweep, stepped on each rising edge from the
    // inputs seen just before that edge.
    bit m_busy = 0, m_done = 0, m_err = 0, m_req = 0, m_ok = 0;
    int m_step = 0, m_idx = 0, m_ptr = 0, m_wait = 0, m_total = 0;
    int m_cnt [4] = '{0, 0, 0, 0};
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_done = 0; m_err = 0; m_req = 0; m_ok = 0;
            m_step = 0; m_idx = 0; m_ptr = 0; m_wait = 0; m_total = 0;
            m_cnt = '{0, 0, 0, 0};
        end else begin
            m_done = 0;
            if (!m_busy) begin
                m_req = 0;
                if (start) begin
                    m_busy = 1; m_err = 0; m_ptr = 0; m_step = 0;
                end
            end else if (m_step == 0) begin
                if (IDLE) begin
                    m_req = 1; m_idx = m_ptr; m_step = 1;
                end
            end else if (m_step == 1) begin
                m_req = 0; m_ok = IDLE; m_wait = 0; m_step = 2;
            end else if (m_step == 2) begin
                if (!m_ok) begin
                    m_step = 0;
                end else if (valid_contador) begin
                    m_cnt[m_ptr] = int'(contador_out);
                    if (m_ptr == N_IDX - 1) begin
                        m_total = m_cnt[0] + m_cnt[1] + m_cnt[2] + m_cnt[3];
                        m_done = 1; m_step = 3;
                    end else begin
                        m_ptr++; m_step = 0;
                    end
                end else begin
                    m_wait++;
                    if (m_wait == TIMEOUT) begin
                        m_err = 1;
                        m_total = m_cnt[0] + m_cnt[1] + m_cnt[2] + m_cnt[3];
                        m_done = 1; m_step = 3;
                    end
                end
            end else begin
                m_busy = 0; m_step = 0;
            end
        end
    end

    // Continuous comparison against the model.
    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req", int'(req), int'(m_req));
            chk("idx", int'(idx), m_idx);
            chk("busy", int'(busy), int'(m_busy));
            chk("done", int'(done), int'(m_done));
            chk("error", int'(error), int'(m_err));
            chk("cnt0", int'(cnt0), m_cnt[0]);
            chk("cnt1", int'(cnt1), m_cnt[1]);
            chk("cnt2", int'(cnt2), m_cnt[2]);
            chk("cnt3", int'(cnt3), m_cnt[3]);
            chk("total", int'(total), m_total);
        end
    end

    // Request log per index.
    int req_hits [4] = '{0, 0, 0, 0};
    always @(negedge clk) begin
        if (req) req_hits[idx]++;
    end

    int req_at [$];
    int req_idx [$];
    int err_after_start;

    // Pulses start and counts falling edges until done (bounded).
    task automatic sweep(output int n);
        req_at.delete();
        req_idx.delete();
        n = 0;
        start = 1'b1;
        @(negedge clk);
        n = 1;
        start = 1'b0;
        err_after_start = int'(error);
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (req) begin
                req_at.push_back(n);
                req_idx.push_back(int'(idx));
            end
        end
        chk("done_reached", int'(done), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w;
        mem = '{3, 7, 0, 31};
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_req", int'(req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_total", int'(total), 0);
        reset = 1'b1;
        IDLE  = 1'b1;
        @(negedge clk);

        // Basic sweep.
        sweep(n);
        chk("basic_latency", n, 13);
        chk("basic_nreq", req_at.size(), 4);
        if (req_at.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("basic_req_at", req_at[i], 2 + 3 * i);
                chk("basic_req_idx", req_idx[i], i);
            end
        end
        chk("basic_cnt0", int'(cnt0), 3);
        chk("basic_cnt3", int'(cnt3), 31);
        chk("basic_total", int'(total), 41);
        chk("basic_error", int'(error), 0);
        repeat (2) @(negedge clk);

        // IDLE gating.
        mem = '{1, 2, 4, 8};
        IDLE = 1'b0;
        req_hits = '{0, 0, 0, 0};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("gate_noreq", req_hits[0], 0);
        chk("gate_busy", int'(busy), 1);
        IDLE = 1'b1;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("gate_latency", n, 12);
        chk("gate_total", int'(total), 15);
        repeat (2) @(negedge clk);

        // IDLE drops at the edge closing the idx=2 request.
        mem = '{5, 6, 9, 10};
        req_hits = '{0, 0, 0, 0};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!(req && idx == 2'd2) && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("drop_found", int'(req && idx == 2'd2), 1);
        IDLE = 1'b0;
        repeat (3) @(negedge clk);
        IDLE = 1'b1;
        w = 0;
        while (!done && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("drop_req2", req_hits[2], 2);
        chk("drop_req1", req_hits[1], 1);
        chk("drop_cnt2", int'(cnt2), 9);
        chk("drop_total", int'(total), 30);
        repeat (2) @(negedge clk);

        // Sticky valid from the responder.
        mem = '{11, 12, 13, 14};
        sticky = 1'b1;
        sweep(n);
        chk("sticky_latency", n, 13);
        chk("sticky_cnt1", int'(cnt1), 12);
        chk("sticky_total", int'(total), 50);
        sticky = 1'b0;
        repeat (2) @(negedge clk);

        // Timeout with counts starting from reset.
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        resp_on = 1'b0;
        sweep(n);
        chk("to_latency", n, 7);
        chk("to_error", int'(error), 1);
        chk("to_cnt0", int'(cnt0), 0);
        chk("to_total", int'(total), 0);
        repeat (3) @(negedge clk);
        chk("to_sticky", int'(error), 1);
        resp_on = 1'b1;
        mem = '{2, 2, 2, 2};
        sweep(n);
        chk("to_clear", err_after_start, 0);
        chk("to_after_err", int'(error), 0);
        chk("to_after_total", int'(total), 8);
        repeat (2) @(negedge clk);

        // Reset while waiting on idx 1.
        mem = '{3, 4, 5, 6};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!(req && idx == 2'd1) && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        chk("mid_cnt0_pre", int'(cnt0), 3);
        #2 reset = 1'b0;
        #1;
        chk("mid_req", int'(req), 0);
        chk("mid_idx", int'(idx), 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_cnt0", int'(cnt0), 0);
        chk("mid_total", int'(total), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        sweep(n);
        chk("mid_first_idx", (req_idx.size() > 0) ? req_idx[0] : -1, 0);
        chk("mid_total2", int'(total), 18);
        repeat (2) @(negedge clk);

        // Maximum counts.
        mem = '{31, 31, 31, 31};
        sweep(n);
        chk("max_total", int'(total), 124);
        chk("max_error", int'(error), 0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
